// File: rtl/q_sym_slicer_mer.sv
// Q-channel symbol-rate back end: 4-ASK slicer with adaptive outer threshold,
// per-symbol decision error, and block statistics (mean |x| -> reference, mean err^2).
module q_sym_slicer_mer #(
  parameter int unsigned        LOG2_N   = 10,
  parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk,
  input  logic               clear_accum,
  input  logic signed [17:0] data_in,
  output logic [1:0]         sym_idx,
  output logic signed [17:0] sym_level,
  output logic signed [17:0] err,
  output logic               sym_valid,
  output logic signed [17:0] ref_level,
  output logic [17:0]        err_pwr,
  output logic               meas_valid
);

  localparam int unsigned AW = 18 + LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {LOG2_N{1'b0}}};

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_LATCH = 1'b1;

  localparam logic signed [19:0] SAT_MAX = 20'sd131071;
  localparam logic signed [19:0] SAT_MIN = -20'sd131072;
  localparam logic signed [17:0] REF_MAX = 18'sd131071;

  logic [1:0]         r_sym_idx;
  logic signed [17:0] r_sym_level;
  logic signed [17:0] r_err;
  logic               r_sym_valid;
  logic signed [17:0] r_ref_level;
  logic [17:0]        r_err_pwr;
  logic               r_meas_valid;
  logic signed [17:0] r_data_d;
  logic [AW-1:0]      r_acc_abs;
  logic [AW-1:0]      r_acc_sq;
  logic [CW-1:0]      r_cnt;
  logic [0:0]         r_state;

  logic signed [18:0] w_ref;
  logic signed [18:0] w_a;
  logic signed [18:0] w_3a;
  logic signed [18:0] w_x;
  logic signed [18:0] w_lvl;
  logic signed [19:0] w_lvl_ext;
  logic signed [19:0] w_err_full;
  logic [1:0]         w_idx;
  logic signed [17:0] w_lvl_sat;
  logic signed [17:0] w_err_sat;

  // Slicer: thresholds at 0 and +/-ref, equality resolves towards the upper level
  always_comb begin
    w_ref = {r_ref_level[17], r_ref_level};
    w_a   = w_ref >>> 1;
    w_3a  = w_ref + w_a;
    w_x   = {data_in[17], data_in};
    w_idx = 2'd0;
    w_lvl = -w_3a;
    if (w_x >= w_ref) begin
      w_idx = 2'd3;
      w_lvl = w_3a;
    end else if (w_x >= 19'sd0) begin
      w_idx = 2'd2;
      w_lvl = w_a;
    end else if (w_x >= -w_ref) begin
      w_idx = 2'd1;
      w_lvl = -w_a;
    end
    w_lvl_ext  = {w_lvl[18], w_lvl};
    w_err_full = {w_x[18], w_x} - w_lvl_ext;

    if (w_lvl_ext > SAT_MAX)      w_lvl_sat = 18'sd131071;
    else if (w_lvl_ext < SAT_MIN) w_lvl_sat = -18'sd131072;
    else                          w_lvl_sat = w_lvl_ext[17:0];

    if (w_err_full > SAT_MAX)      w_err_sat = 18'sd131071;
    else if (w_err_full < SAT_MIN) w_err_sat = -18'sd131072;
    else                           w_err_sat = w_err_full[17:0];
  end

  logic [17:0]        w_abs;
  logic signed [35:0] w_sq;
  logic [17:0]        w_sq_sl;
  logic [AW-1:0]      w_mean_abs;
  logic [AW-1:0]      w_mean_sq;
  logic signed [17:0] w_ref_new;

  // |-131072| is 131072, representable because w_abs is unsigned 18-bit
  assign w_abs      = r_data_d[17] ? ($unsigned(~r_data_d) + 18'd1) : $unsigned(r_data_d);
  assign w_sq       = r_err * r_err;
  assign w_sq_sl    = 18'(w_sq >>> 17);
  assign w_mean_abs = r_acc_abs >> LOG2_N;
  assign w_mean_sq  = r_acc_sq >> LOG2_N;
  assign w_ref_new  = (w_mean_abs > AW'(131071)) ? REF_MAX : $signed(18'(w_mean_abs));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sym_idx    <= '0;
      r_sym_level  <= '0;
      r_err        <= '0;
      r_sym_valid  <= 1'b0;
      r_ref_level  <= REF_INIT;
      r_err_pwr    <= '0;
      r_meas_valid <= 1'b0;
      r_data_d     <= '0;
      r_acc_abs    <= '0;
      r_acc_sq     <= '0;
      r_cnt        <= '0;
      r_state      <= ST_ACCUM;
    end else begin
      r_sym_valid  <= sym_clk;
      r_meas_valid <= 1'b0;
      if (sym_clk) begin
        r_sym_idx   <= w_idx;
        r_sym_level <= w_lvl_sat;
        r_err       <= w_err_sat;
        r_data_d    <= data_in;
      end

      if (clear_accum) begin
        r_acc_abs <= '0;
        r_acc_sq  <= '0;
        r_cnt     <= '0;
        r_state   <= ST_ACCUM;
      end else if (r_state == ST_LATCH) begin
        r_ref_level  <= w_ref_new;
        r_err_pwr    <= 18'(w_mean_sq);
        r_meas_valid <= 1'b1;
        r_state      <= ST_ACCUM;
        // A symbol landing on the latch clk opens the next block
        if (r_sym_valid) begin
          r_acc_abs <= AW'(w_abs);
          r_acc_sq  <= AW'(w_sq_sl);
          r_cnt     <= CW'(1);
        end else begin
          r_acc_abs <= '0;
          r_acc_sq  <= '0;
          r_cnt     <= '0;
        end
      end else if (r_sym_valid) begin
        r_acc_abs <= r_acc_abs + AW'(w_abs);
        r_acc_sq  <= r_acc_sq + AW'(w_sq_sl);
        r_cnt     <= r_cnt + CW'(1);
        if (r_cnt + CW'(1) == CNT_FULL) r_state <= ST_LATCH;
      end
    end
  end

  assign sym_idx    = r_sym_idx;
  assign sym_level  = r_sym_level;
  assign err        = r_err;
  assign sym_valid  = r_sym_valid;
  assign ref_level  = r_ref_level;
  assign err_pwr    = r_err_pwr;
  assign meas_valid = r_meas_valid;

endmodule
